// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//   Frame-level scheduler sitting above the pixel sensor state machine.
//   Arbitrates single-shot and continuous capture requests, latches the
//   exposure length per frame, issues a one-cycle start to the sensor core,
//   waits for the core's frame-done pulse, enforces an inter-frame gap,
//   counts completed frames and flags timeouts and lost requests.
//
// Parameters
//   EXP_W          width of exposure length (clk cycles)
//   GAP_CYCLES     idle cycles forced between frame-done and next launch (0 ok)
//   TIMEOUT_CYCLES maximum RUN cycles before a frame is declared failed (>=2)
//   FRAME_CNT_W    width of the completed-frame counter
//
// Ports
//   clk                   main clock
//   reset                 asynchronous, active-low reset
//   single_req            single-shot request, rising edge detected here
//   cont_en               continuous capture while high
//   expose_cycles         requested exposure length
//   abort                 synchronous abort of current or pending work
//   err_clr               clears the sticky error flags
//   sensor_start          one-cycle start pulse to the sensor core
//   sensor_expose_cycles  exposure length latched for the current frame
//   sensor_done           one-cycle end-of-readout pulse from the core
//   busy                  high in LAUNCH, RUN and GAP
//   single_ack            one-cycle pulse when a single-shot frame completes
//   frame_count           completed frames, wraps
//   timeout_err           sticky timeout flag
//   overrun               sticky lost-request flag
// -----------------------------------------------------------------------------
module frame_scheduler #(
  parameter int EXP_W          = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   single_req,
  input  logic                   cont_en,
  input  logic [EXP_W-1:0]       expose_cycles,
  input  logic                   abort,
  input  logic                   err_clr,
  output logic                   sensor_start,
  output logic [EXP_W-1:0]       sensor_expose_cycles,
  input  logic                   sensor_done,
  output logic                   busy,
  output logic                   single_ack,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_GAP
  } state_t;

  state_t           state;
  logic             single_req_q;
  logic             pending;
  logic             kind_single;
  logic [TO_W-1:0]  run_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             req_edge;
  logic             req_lost;
  logic [EXP_W-1:0] exp_clamped;

  assign req_edge    = single_req & ~single_req_q;
  // An edge arriving while one request is already queued has nowhere to go.
  assign req_lost    = req_edge & pending & ~abort;
  assign exp_clamped = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      single_req_q         <= 1'b0;
      pending              <= 1'b0;
      kind_single          <= 1'b0;
      run_cnt              <= '0;
      gap_cnt              <= '0;
      sensor_start         <= 1'b0;
      sensor_expose_cycles <= '0;
      busy                 <= 1'b0;
      single_ack           <= 1'b0;
      frame_count          <= '0;
      timeout_err          <= 1'b0;
      overrun              <= 1'b0;
    end else begin
      single_req_q <= single_req;
      sensor_start <= 1'b0;
      single_ack   <= 1'b0;

      // Clear first so that a same-cycle set (assigned later) wins.
      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end
      if (req_lost) overrun <= 1'b1;

      // Edges seen while busy are queued; in IDLE they launch directly below.
      if (abort) pending <= 1'b0;
      else if (req_edge && state != S_IDLE) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!abort && (pending || req_edge || cont_en)) begin
            state                <= S_LAUNCH;
            sensor_start         <= 1'b1;
            busy                 <= 1'b1;
            sensor_expose_cycles <= exp_clamped;
            // A queued or fresh single always beats continuous mode.
            kind_single          <= pending | req_edge;
            pending              <= 1'b0;
          end
        end

        S_LAUNCH: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= S_RUN;
            run_cnt <= '0;
          end
        end

        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (sensor_done || run_cnt == TO_LAST) begin
            if (sensor_done) begin
              frame_count <= frame_count + FRAME_CNT_W'(1);
              single_ack  <= kind_single;
            end else begin
              timeout_err <= 1'b1;
            end
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else begin
            run_cnt <= run_cnt + TO_W'(1);
          end
        end

        S_GAP: begin
          if (abort || gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//   Self-checking bench for frame_scheduler. Expected behaviour is predicted
//   as a timeline: a frame launched at cycle S with the core answering after
//   d cycles acks at S+d+1, stays busy through S+d+GAP, and a following launch
//   lands at S+d+GAP+2. A simple core model answers sensor_start after a
//   programmable delay.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

  localparam int EXP_W = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int FCW   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             single_req;
  logic             cont_en;
  logic [EXP_W-1:0] expose_cycles;
  logic             abort;
  logic             err_clr;
  logic             sensor_start;
  logic [EXP_W-1:0] sensor_expose_cycles;
  logic             sensor_done;
  logic             busy;
  logic             single_ack;
  logic [FCW-1:0]   frame_count;
  logic             timeout_err;
  logic             overrun;

  frame_scheduler #(
    .EXP_W(EXP_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .FRAME_CNT_W(FCW)
  ) dut (
    .clk(clk), .reset(reset), .single_req(single_req), .cont_en(cont_en),
    .expose_cycles(expose_cycles), .abort(abort), .err_clr(err_clr),
    .sensor_start(sensor_start), .sensor_expose_cycles(sensor_expose_cycles),
    .sensor_done(sensor_done), .busy(busy), .single_ack(single_ack),
    .frame_count(frame_count), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int core_delay = 0;   // 0: core never answers on its own
  int since  = -1;      // cycles since the last observed start, -1 when idle
  int exp_frames = 0;   // reference count of completed frames
  int start_q[$];
  int ack_q[$];

  function automatic logic [EXP_W-1:0] clamp(input int e);
    return (e == 0) ? EXP_W'(1) : EXP_W'(e);
  endfunction

  // One clock: outputs observed 1 ns after the edge, core model updated.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sensor_done = 1'b0;
    if (sensor_start === 1'b1) begin
      start_q.push_back(cyc);
      since = 0;
    end else if (since >= 0) begin
      since++;
    end
    if (single_ack === 1'b1) ack_q.push_back(cyc);
    if (core_delay > 0 && since == core_delay) begin
      sensor_done = 1'b1;
      since = -1;
    end
  endtask

  task automatic clear_log();
    start_q.delete();
    ack_q.delete();
    since = -1;
  endtask

  task automatic pulse_req();
    single_req = 1'b1;
    tick();
    single_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({sensor_start, busy, single_ack, timeout_err, overrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000",
               {sensor_start, busy, single_ack, timeout_err, overrun});
    end
    checks++;
    if (frame_count !== '0 || sensor_expose_cycles !== '0) begin
      fails++;
      $display("FAIL reset_data: got count=%0d exp=%0d expected 0/0", frame_count, sensor_expose_cycles);
    end
    // Complete one frame, then start another and reset it mid-RUN.
    clear_log();
    expose_cycles = 8'd7;
    core_delay = 5;
    pulse_req();
    repeat (15) tick();
    exp_frames = 1;
    checks++;
    if (frame_count !== FCW'(exp_frames)) begin
      fails++;
      $display("FAIL pre_reset_count: got %0d expected %0d", frame_count, exp_frames);
    end
    core_delay = 0;
    pulse_req();
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    exp_frames = 0;
    checks++;
    if ({sensor_start, busy, single_ack, timeout_err, overrun} !== 5'b0 ||
        frame_count !== '0 || sensor_expose_cycles !== '0) begin
      fails++;
      $display("FAIL async_reset: got flags=%b count=%0d exp=%0d expected all 0",
               {sensor_start, busy, single_ack, timeout_err, overrun}, frame_count, sensor_expose_cycles);
    end
    repeat (2) tick();
    reset = 1'b1;
    clear_log();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_busy: cycle %0d got %b expected 0", i, busy);
      end
    end
    checks++;
    if (start_q.size() != 0) begin
      fails++;
      $display("FAIL idle_no_start: got %0d starts expected 0", start_q.size());
    end
  endtask

  task automatic test_single(input int e, input int d);
    int s;
    clear_log();
    core_delay = d;
    expose_cycles = EXP_W'(e);
    pulse_req();
    s = cyc;
    checks++;
    if (sensor_start !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_start_latency: got start=%b busy=%b expected 1/1", sensor_start, busy);
    end
    checks++;
    if (sensor_expose_cycles !== clamp(e)) begin
      fails++;
      $display("FAIL single_expose: got %0d expected %0d", sensor_expose_cycles, clamp(e));
    end
    expose_cycles = EXP_W'($urandom);
    while (cyc < s + d + GAP + 1) begin
      tick();
      checks++;
      if (busy !== ((cyc <= s + d + GAP) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL single_busy: cycle %0d after start got %b", cyc - s, busy);
      end
    end
    exp_frames++;
    checks++;
    if (frame_count !== FCW'(exp_frames)) begin
      fails++;
      $display("FAIL single_count: got %0d expected %0d", frame_count, exp_frames);
    end
    checks++;
    if (ack_q.size() != 1 || ack_q[0] != s + d + 1) begin
      fails++;
      $display("FAIL single_ack: got %0d acks (first at +%0d) expected 1 at +%0d",
               ack_q.size(), (ack_q.size() > 0) ? ack_q[0] - s : -1, d + 1);
    end
    checks++;
    if (sensor_expose_cycles !== clamp(e) || start_q.size() != 1) begin
      fails++;
      $display("FAIL single_hold: got exp=%0d starts=%0d expected %0d/1",
               sensor_expose_cycles, start_q.size(), clamp(e));
    end
  endtask

  task automatic test_continuous(input int d);
    bit req_sent = 0;
    bit done = 0;
    clear_log();
    core_delay = d;
    cont_en = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      single_req = 1'b0;
      if (start_q.size() == 2 && since == 5 && !req_sent) begin
        single_req = 1'b1;
        req_sent = 1;
      end
      if (start_q.size() >= 5) cont_en = 1'b0;
      if (start_q.size() >= 5 && busy === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL cont_budget: got %0d starts before budget expired expected 5", start_q.size());
    end
    repeat (d + GAP + 5) tick();
    exp_frames += 5;
    checks++;
    if (start_q.size() != 5) begin
      fails++;
      $display("FAIL cont_starts: got %0d expected 5", start_q.size());
    end
    for (int k = 1; k < start_q.size(); k++) begin
      checks++;
      if (start_q[k] - start_q[k-1] != d + GAP + 2) begin
        fails++;
        $display("FAIL cont_spacing: frame %0d got %0d expected %0d", k, start_q[k] - start_q[k-1], d + GAP + 2);
      end
    end
    checks++;
    if (frame_count !== FCW'(exp_frames)) begin
      fails++;
      $display("FAIL cont_count: got %0d expected %0d", frame_count, exp_frames);
    end
    checks++;
    if (start_q.size() < 3 || ack_q.size() != 1 || ack_q[0] != start_q[2] + d + 1) begin
      fails++;
      $display("FAIL cont_single_ack: got %0d acks expected 1 on the third frame", ack_q.size());
    end
  endtask

  task automatic test_timeout();
    int s;
    clear_log();
    core_delay = 0;
    pulse_req();
    s = cyc;
    while (cyc < s + TMO) tick();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: got err=%b busy=%b expected 0/1", timeout_err, busy);
    end
    err_clr = 1'b1;   // coincides with the timeout set
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_set: got %b expected 1", timeout_err);
    end
    while (cyc < s + TMO + GAP + 1) begin
      tick();
      checks++;
      if (busy !== ((cyc <= s + TMO + GAP) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL timeout_gap_busy: cycle %0d after start got %b", cyc - s, busy);
      end
    end
    checks++;
    if (frame_count !== FCW'(exp_frames) || ack_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_no_count: got count=%0d acks=%0d expected %0d/0", frame_count, ack_q.size(), exp_frames);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_abort();
    int s, k;
    clear_log();
    core_delay = 0;
    expose_cycles = '0;
    pulse_req();
    s = cyc;
    checks++;
    if (sensor_expose_cycles !== 8'd1) begin
      fails++;
      $display("FAIL abort_clamp: got %0d expected 1", sensor_expose_cycles);
    end
    k = $urandom_range(2, 40);
    while (cyc < s + k) tick();
    abort = 1'b1;
    sensor_done = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b expected 0", busy);
    end
    repeat (3) tick();
    sensor_done = 1'b1;   // stray done in IDLE
    repeat (10) tick();
    checks++;
    if (frame_count !== FCW'(exp_frames) || ack_q.size() != 0 || start_q.size() != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_count: got count=%0d acks=%0d starts=%0d busy=%b expected %0d/0/1/0",
               frame_count, ack_q.size(), start_q.size(), busy, exp_frames);
    end
    clear_log();
    single_req = 1'b1;
    abort = 1'b1;
    tick();
    single_req = 1'b0;
    abort = 1'b0;
    repeat (10) tick();
    checks++;
    if (start_q.size() != 0) begin
      fails++;
      $display("FAIL abort_edge_discard: got %0d starts expected 0", start_q.size());
    end
  endtask

  task automatic test_overrun();
    int s;
    bit done = 0;
    clear_log();
    core_delay = 30;
    expose_cycles = EXP_W'($urandom_range(0, 255));
    pulse_req();
    s = cyc;
    while (cyc < s + 16) begin
      tick();
      single_req = (cyc == s + 5 || cyc == s + 10 || cyc == s + 15) ? 1'b1 : 1'b0;
      if (cyc == s + 7) begin
        checks++;
        if (overrun !== 1'b0) begin
          fails++;
          $display("FAIL overrun_first_queued: got %b expected 0", overrun);
        end
      end
    end
    single_req = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (start_q.size() >= 2 && busy === 1'b0) done = 1;
    end
    repeat (10) tick();
    exp_frames += 2;
    checks++;
    if (start_q.size() != 2 || start_q[1] != s + 30 + GAP + 2) begin
      fails++;
      $display("FAIL overrun_extra_frame: got %0d starts (second at +%0d) expected 2 at +%0d",
               start_q.size(), (start_q.size() > 1) ? start_q[1] - s : -1, 30 + GAP + 2);
    end
    checks++;
    if (ack_q.size() != 2 || frame_count !== FCW'(exp_frames) || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_acks: got acks=%0d count=%0d overrun=%b expected 2/%0d/1",
               ack_q.size(), frame_count, overrun, exp_frames);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    single_req = 1'b0;
    cont_en = 1'b0;
    expose_cycles = '0;
    abort = 1'b0;
    err_clr = 1'b0;
    sensor_done = 1'b0;
    test_reset();
    test_single(10, 50);
    repeat (3) test_single(int'($urandom_range(0, 255)), int'($urandom_range(1, 60)));
    test_single(0, 1);
    test_continuous(20);
    test_continuous(int'($urandom_range(8, 40)));
    test_timeout();
    test_abort();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Frame-level scheduler above the pixel sensor state machine. It arbitrates between single-shot and continuous capture requests, latches the exposure length for each frame, and issues a one-cycle start to the sensor core. It waits for the core's frame-done pulse, enforces a minimum inter-frame gap, counts completed frames, and flags timeouts and request overruns.

Parameters:
EXP_W, 8, width of exposure length in clk cycles
GAP_CYCLES, 4, idle cycles forced between frame-done and the next launch (0 allowed)
TIMEOUT_CYCLES, 1024, maximum RUN cycles before the frame is declared failed (>=2)
FRAME_CNT_W, 16, width of completed-frame counter

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-low reset
single_req  in  1  single-shot request; rising edge detected internally
cont_en  in  1  level; continuous capture while high
expose_cycles  in  EXP_W  requested exposure length
abort  in  1  synchronous abort of current or pending work
err_clr  in  1  clears sticky error flags
sensor_start  out  1  one-cycle start pulse to sensor core
sensor_expose_cycles  out  EXP_W  exposure length latched for current frame
sensor_done  in  1  one-cycle pulse from core at end of readout
busy  out  1  high in LAUNCH, RUN, GAP
single_ack  out  1  one-cycle pulse when a single-shot frame completes
frame_count  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W
timeout_err  out  1  sticky timeout flag
overrun  out  1  sticky lost-request flag

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. pending and edge-detect register cleared.
- edge = single_req & ~single_req_q. edge sets pending.
- IDLE: if (pending | edge) -> LAUNCH, kind=single, pending cleared. Else if cont_en -> LAUNCH, kind=cont. Else stay.
- On IDLE->LAUNCH: sensor_expose_cycles <= expose_cycles. A value of 0 is clamped to 1. It is held until the next launch.
- LAUNCH: sensor_start=1 for exactly this cycle; next state RUN. Latency from edge sampled in IDLE to sensor_start is 1 cycle.
- RUN: timeout counter starts at 0 and increments each cycle.
  - sensor_done=1 -> GAP; frame_count+1. If kind=single, single_ack=1 in the first GAP cycle.
  - Counter reaches TIMEOUT_CYCLES-1 with no done -> timeout_err=1, then GAP. No count, no ack.
- GAP: GAP_CYCLES cycles, then IDLE. If GAP_CYCLES=0, RUN exits directly to IDLE.
- sensor_done outside RUN is ignored.
- abort:
  - In LAUNCH/RUN/GAP -> IDLE next cycle. pending cleared, no count, no ack.
  - abort wins over a simultaneous sensor_done.
  - In IDLE it clears pending and blocks a launch that cycle.
  - An edge coincident with abort is discarded.
- overrun=1 when an edge occurs while pending=1, or while busy and pending=1. A request that is not lost is queued (pending) and served after the current frame.
- err_clr clears timeout_err and overrun. A same-cycle set wins over the clear.
- cont_en falling mid-frame: the current frame completes normally; no further launch.
- Pending single has priority over continuous at every IDLE decision.

Test Plan:
1. Hold reset low mid-RUN -> all outputs 0 immediately, state IDLE. After release with no requests -> busy=0 and no sensor_start for 20 cycles.
2. expose_cycles=10, single_req pulse at cycle N -> sensor_start high at N+1 and sensor_expose_cycles=10. Done after 50 cycles -> frame_count=1, single_ack one cycle, busy falls after 4 GAP cycles.
3. cont_en=1, core model pulses done 20 cycles after each start -> sensor_start pulses exactly 26 cycles apart and frame_count=5 after 5 dones. A single_req mid-frame -> the next frame yields single_ack.
4. TIMEOUT_CYCLES=64, no done -> timeout_err=1 after 64 RUN cycles, frame_count unchanged, IDLE after gap. err_clr -> timeout_err=0.
5. abort together with sensor_done in RUN -> IDLE next cycle, no count, no ack. A later stray done is ignored. expose_cycles=0 at launch -> sensor_expose_cycles=1.
6. Three single_req pulses during one busy frame -> overrun=1, exactly one extra frame and one extra single_ack.
